// File: rtl/adam_aes_ctr_stream_pkg.sv
// Shared types and counter helpers for the AES-CTR stream engine.
package adam_aes_ctr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_INIT,
    KEY_WAIT,
    RUN,
    DRAIN
  } state_t;

  typedef logic [127:0] blk_t;

  typedef struct packed {
    blk_t data;
    logic last;
  } entry_t;

  function automatic blk_t ctr_mask(input int w);
    blk_t m;
    m = '0;
    for (int i = 0; i < 128; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

  // Only the low w bits count; the upper nonce part never sees the carry.
  function automatic blk_t ctr_inc(input blk_t c, input int w);
    blk_t m;
    blk_t n;
    m = ctr_mask(w);
    n = c + 128'd1;
    return (c & ~m) | (n & m);
  endfunction

endpackage

// File: rtl/adam_aes_ctr_stream_if.sv
// Plaintext-in / ciphertext-out valid/ready stream bundle.
interface adam_aes_ctr_stream_if;
  import adam_aes_ctr_pkg::*;

  logic s_valid;
  logic s_ready;
  blk_t s_data;
  logic s_last;
  logic m_valid;
  logic m_ready;
  blk_t m_data;
  logic m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/adam_aes_ctr_stream_fifo.sv
// Synchronous entry FIFO with occupancy count.
module adam_aes_ctr_fifo
  import adam_aes_ctr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  assign dout  = mem[rp];
  assign full  = count == FULL_CNT;
  assign empty = count == '0;

endmodule

// File: rtl/adam_aes_ctr_stream.sv
// AES-CTR streaming engine around an external pipelined encipher.
// ADAM_AES_CTR_WRAP_STOP_EN: end the message when the counter wraps.
module adam_aes_ctr_stream
  import adam_aes_ctr_pkg::*;
#(
  parameter int PIPE_LAT = 11,
  parameter int DEPTH    = 16,
  parameter int CTR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  blk_t                 iv,
  input  logic [255:0]         key,
  input  logic                 keylen,
  adam_aes_ctr_stream_if.slave strm,
  output logic                 kx_init,
  input  logic                 kx_ready,
  output logic                 enc_start,
  output blk_t                 enc_block,
  input  logic                 enc_valid,
  input  blk_t                 enc_result,
  output logic                 busy,
  output logic                 ctr_wrap,
  output logic [31:0]          blk_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam blk_t LOW_MASK = ctr_mask(CTR_W);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  state_t state, state_n;
  blk_t ctr_q;
  logic [255:0] key_q;
  logic keylen_q;
  logic key_ok;
  logic [CW-1:0] credit;

  logic accept, m_fire, need_kx, start_ok;
  logic wrap_hit, stop, run_like;
  entry_t d_din, d_dout, o_din, o_dout;
  logic d_pop;
  logic d_full, d_empty, o_full, o_empty;
  logic [CW-1:0] d_count, o_count;

  assign start_ok = start && state == IDLE;
  assign need_kx  = !key_ok || key != key_q
                 || keylen != keylen_q;
  assign wrap_hit = (ctr_q & LOW_MASK) == LOW_MASK;

`ifdef ADAM_AES_CTR_WRAP_STOP_EN
  assign stop = wrap_hit;
`else
  assign stop = 1'b0;
`endif

  assign strm.s_ready = state == RUN && credit < CMAX;
  assign accept    = strm.s_valid && strm.s_ready;
  assign m_fire    = strm.m_valid && strm.m_ready;
  assign enc_start = accept;
  assign enc_block = ctr_q;
  assign busy      = state != IDLE;
  assign run_like  = state == RUN || state == DRAIN;

  always_comb begin
    state_n = state;
    kx_init = 1'b0;
    unique case (state)
      IDLE:
        if (start) state_n = need_kx ? KEY_INIT : RUN;
      KEY_INIT: begin
        kx_init = 1'b1;
        state_n = KEY_WAIT;
      end
      KEY_WAIT:
        if (kx_ready) state_n = RUN;
      RUN:
        if (accept && (strm.s_last || stop))
          state_n = DRAIN;
      DRAIN:
        if (credit == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ctr_q     <= '0;
      key_q     <= '0;
      keylen_q  <= 1'b0;
      key_ok    <= 1'b0;
      credit    <= '0;
      ctr_wrap  <= 1'b0;
      blk_count <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        ctr_q     <= iv;
        key_q     <= key;
        keylen_q  <= keylen;
        ctr_wrap  <= 1'b0;
        blk_count <= '0;
        if (need_kx) key_ok <= 1'b0;
      end
      if (state == KEY_WAIT && kx_ready)
        key_ok <= 1'b1;
      if (accept) begin
        ctr_q <= ctr_inc(ctr_q, CTR_W);
        if (wrap_hit) ctr_wrap <= 1'b1;
      end
      if (m_fire) blk_count <= blk_count + 32'd1;
      unique case ({accept, m_fire})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: ;
      endcase
    end
  end

  assign d_din = '{data: strm.s_data,
                   last: strm.s_last | stop};

  // Keystream with nothing queued is a stale pipeline beat after reset.
  assign d_pop = enc_valid && !d_empty;
  assign o_din = '{data: d_dout.data ^ enc_result,
                   last: d_dout.last};

  adam_aes_ctr_fifo #(.DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (d_din),
    .pop   (d_pop),
    .dout  (d_dout),
    .full  (d_full),
    .empty (d_empty),
    .count (d_count)
  );

  adam_aes_ctr_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (d_pop),
    .din   (o_din),
    .pop   (m_fire),
    .dout  (o_dout),
    .full  (o_full),
    .empty (o_empty),
    .count (o_count)
  );

  assign strm.m_valid = !o_empty;
  assign strm.m_data  = o_empty ? '0 : o_dout.data;
  assign strm.m_last  = !o_empty && o_dout.last;

  a_depth: assert property (
    @(posedge clk) DEPTH >= PIPE_LAT + 2);
  a_ks_orphan: assert property (
    @(posedge clk) disable iff (reset)
    enc_valid && run_like |-> !d_empty);
  a_d_ovf: assert property (
    @(posedge clk) disable iff (reset)
    !(accept && d_full));
  a_o_ovf: assert property (
    @(posedge clk) disable iff (reset)
    !(d_pop && o_full));
  a_credit: assert property (
    @(posedge clk) disable iff (reset)
    d_count <= credit && o_count <= credit);

endmodule

// File: tb/tb_adam_aes_ctr_stream.sv
// Directed bench for adam_aes_ctr_stream with a modelled encipher pipeline.
module tb_adam_aes_ctr_stream;
  import adam_aes_ctr_pkg::*;

  localparam int PIPE_LAT = 11;
  localparam int DEPTH    = 16;

  typedef struct {
    blk_t pt;
    logic last;
    blk_t ct;
    logic exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  blk_t iv;
  logic [255:0] key;
  logic keylen;
  logic kx_init;
  logic kx_ready = 1'b0;
  logic enc_start;
  blk_t enc_block;
  logic enc_valid;
  blk_t enc_result;
  logic busy;
  logic ctr_wrap;
  logic [31:0] blk_count;

  adam_aes_ctr_stream_if sif();

  adam_aes_ctr_stream #(
    .PIPE_LAT (PIPE_LAT),
    .DEPTH    (DEPTH),
    .CTR_W    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .iv         (iv),
    .key        (key),
    .keylen     (keylen),
    .strm       (sif),
    .kx_init    (kx_init),
    .kx_ready   (kx_ready),
    .enc_start  (enc_start),
    .enc_block  (enc_block),
    .enc_valid  (enc_valid),
    .enc_result (enc_result),
    .busy       (busy),
    .ctr_wrap   (ctr_wrap),
    .blk_count  (blk_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  vec_t nv [4];
  blk_t nctr [4];

  // NIST keystream for the four F.5.1 counters, a fixed scramble otherwise
  function automatic blk_t ks(input blk_t b);
    for (int i = 0; i < 4; i++)
      if (b == nctr[i]) return nv[i].pt ^ nv[i].ct;
    return {b[63:0], ~b[127:64]} ^ 128'h5a5a_3c3c_0f0f_9696_a5a5_c3c3_f0f0_6969;
  endfunction

  function automatic blk_t ctr_at(input blk_t b, input int i);
    return {b[127:32], b[31:0] + 32'(i)};
  endfunction

  function automatic blk_t bpd(input int i);
    return {4{32'h5eed_0000 + 32'(i)}};
  endfunction

  logic pv [PIPE_LAT] = '{default: 1'b0};
  blk_t pd [PIPE_LAT];
  assign enc_valid  = pv[PIPE_LAT-1];
  assign enc_result = pd[PIPE_LAT-1];

  always @(posedge clk) begin
    pv[0] <= enc_start;
    pd[0] <= ks(enc_block);
    for (int i = 1; i < PIPE_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  int kx_cnt = 0;
  always @(posedge clk) begin
    if (kx_init) begin
      kx_ready <= 1'b0;
      kx_cnt   <= 3;
    end else if (kx_cnt > 0) begin
      kx_cnt <= kx_cnt - 1;
      if (kx_cnt == 1) kx_ready <= 1'b1;
    end
  end

  entry_t out_q [$];
  blk_t iss_q [$];
  int kx_pulses = 0;

  always @(negedge clk) begin
    if (sif.m_valid && sif.m_ready)
      out_q.push_back('{data: sif.m_data, last: sif.m_last});
    if (enc_start) iss_q.push_back(enc_block);
    if (kx_init) kx_pulses++;
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input blk_t act, input blk_t exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input blk_t v);
    iv = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_blk(input blk_t d, input logic last);
    int t;
    t = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    @(negedge clk);
    while (!sif.s_ready && t < 300) begin
      tick();
      @(negedge clk);
      t++;
    end
    if (!sif.s_ready) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: got s_ready=0 want 1");
    end
    tick();
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 400) begin
      tick();
      t++;
    end
    if (out_q.size() < n) begin
      vecs++;
      errs++;
      $display("FAIL out_timeout: got %0d blocks want %0d", out_q.size(), n);
    end
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (busy && t < 400) begin
      tick();
      t++;
    end
    chk_b("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    blk_t iv2, iv3, iv4, snap;
    int idx, kxp, mv_seen;
    logic acc;

    nv[0] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a, last: 1'b0,
              ct: 128'h874d6191b620e3261bef6864990db6ce, exp_last: 1'b0};
    nv[1] = '{pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51, last: 1'b0,
              ct: 128'h9806f66b7970fdff8617187bb9fffdff, exp_last: 1'b0};
    nv[2] = '{pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef, last: 1'b0,
              ct: 128'h5ae4df3edbd5d35e5b4f09020db03eab, exp_last: 1'b0};
    nv[3] = '{pt: 128'hf69f2445df4f9b17ad2b417be66c3710, last: 1'b1,
              ct: 128'h1e031dda2fbe03d1792170a0f3009cee, exp_last: 1'b1};
    nctr[0] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    nctr[1] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    nctr[2] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
    nctr[3] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;

    reset = 1'b1;
    start = 1'b0;
    iv = '0;
    key = '0;
    keylen = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    sif.s_last = 1'b0;
    sif.m_ready = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    chk_b("rst_s_ready", sif.s_ready, 1'b0);
    chk_b("rst_m_valid", sif.m_valid, 1'b0);
    chk_b("rst_m_last", sif.m_last, 1'b0);
    chk_w("rst_m_data", sif.m_data, '0);
    chk_b("rst_kx_init", kx_init, 1'b0);
    chk_b("rst_enc_start", enc_start, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_ctr_wrap", ctr_wrap, 1'b0);
    chk_i("rst_blk_count", int'(blk_count), 0);
    tick();
    reset = 1'b0;
    tick();

    // NIST SP800-38A F.5.1
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    keylen = 1'b0;
    do_start(nctr[0]);
    @(negedge clk);
    chk_b("nist_kx_init", kx_init, 1'b1);
    chk_b("nist_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) send_blk(nv[i].pt, nv[i].last);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      chk_w($sformatf("nist_ct%0d", i), out_q[i].data, nv[i].ct);
      chk_b($sformatf("nist_last%0d", i), out_q[i].last, nv[i].exp_last);
      chk_w($sformatf("nist_ctr%0d", i), iss_q[i], nctr[i]);
    end
    wait_idle();
    chk_i("nist_blk_count", int'(blk_count), 4);
    chk_i("nist_kx_pulses", kx_pulses, 1);

    // same key again: no re-expansion, issue right after start
    out_q.delete();
    iss_q.delete();
    iv = nctr[0];
    start = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data = nv[0].pt;
    sif.s_last = 1'b0;
    @(negedge clk);
    chk_b("b2b_idle_no_issue", enc_start, 1'b0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk_b("b2b_issue_next", enc_start, 1'b1);
    tick();
    sif.s_valid = 1'b0;
    for (int i = 1; i < 4; i++) send_blk(nv[i].pt, nv[i].last);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      chk_w($sformatf("b2b_ct%0d", i), out_q[i].data, nv[i].ct);
      chk_b($sformatf("b2b_last%0d", i), out_q[i].last, nv[i].exp_last);
    end
    wait_idle();
    chk_i("b2b_kx_pulses", kx_pulses, 1);

    // back-pressure: 40 stalled cycles, then release and finish at 20
    out_q.delete();
    iss_q.delete();
    iv2 = 128'ha5a5a5a5_0badf00d_12345678_00000010;
    sif.m_ready = 1'b0;
    do_start(iv2);
    idx = 0;
    snap = '0;
    for (int c = 0; c < 70; c++) begin
      sif.m_ready = c >= 40;
      sif.s_valid = idx < 20;
      sif.s_data = bpd(idx);
      sif.s_last = idx == 19;
      @(negedge clk);
      acc = sif.s_valid && sif.s_ready;
      if (c == 20) snap = sif.m_data;
      if (c == 39) begin
        chk_i("bp_accepted", idx, DEPTH);
        chk_b("bp_s_ready_low", sif.s_ready, 1'b0);
        chk_b("bp_m_valid", sif.m_valid, 1'b1);
        chk_w("bp_m_data_stable", sif.m_data, snap);
        chk_w("bp_m_data_head", sif.m_data, bpd(0) ^ ks(ctr_at(iv2, 0)));
      end
      if (c >= 41 && c <= 44)
        chk_b($sformatf("bp_credit_hold_c%0d", c), sif.s_ready, 1'b1);
      tick();
      if (acc) idx++;
    end
    sif.s_valid = 1'b0;
    sif.s_last = 1'b0;
    wait_out(20);
    for (int i = 0; i < 20; i++) begin
      chk_w($sformatf("bp_ct%0d", i), out_q[i].data, bpd(i) ^ ks(ctr_at(iv2, i)));
      chk_b($sformatf("bp_last%0d", i), out_q[i].last, i == 19);
    end
    wait_idle();
    chk_i("bp_blk_count", int'(blk_count), 20);
    chk_i("bp_issued", iss_q.size(), 20);

    // low counter wrap
    out_q.delete();
    iss_q.delete();
    iv3 = 128'h0123456789abcdef01234567ffffffff;
    do_start(iv3);
`ifdef ADAM_AES_CTR_WRAP_STOP_EN
    send_blk(bpd(100), 1'b0);
    @(negedge clk);
    chk_b("wrap_stop_s_ready", sif.s_ready, 1'b0);
    tick();
    wait_out(1);
    chk_w("wrap_ct0", out_q[0].data, bpd(100) ^ ks(iv3));
    chk_b("wrap_last0", out_q[0].last, 1'b1);
    wait_idle();
    chk_i("wrap_issued", iss_q.size(), 1);
`else
    send_blk(bpd(100), 1'b0);
    send_blk(bpd(101), 1'b1);
    wait_out(2);
    chk_w("wrap_ctr0", iss_q[0], iv3);
    chk_w("wrap_ctr1", iss_q[1], {iv3[127:32], 32'h0});
    chk_w("wrap_ct0", out_q[0].data, bpd(100) ^ ks(iv3));
    chk_w("wrap_ct1", out_q[1].data, bpd(101) ^ ks({iv3[127:32], 32'h0}));
    chk_b("wrap_last0", out_q[0].last, 1'b0);
    chk_b("wrap_last1", out_q[1].last, 1'b1);
    wait_idle();
`endif
    chk_b("wrap_flag", ctr_wrap, 1'b1);

    // reset while blocks are in flight
    out_q.delete();
    iss_q.delete();
    iv4 = 128'h11112222_33334444_55556666_00000000;
    do_start(iv4);
    @(negedge clk);
    chk_b("start_clears_wrap", ctr_wrap, 1'b0);
    tick();
    kxp = kx_pulses;
    idx = 0;
    for (int c = 0; c < 100 && out_q.size() < 2; c++) begin
      sif.s_valid = 1'b1;
      sif.s_data = bpd(200 + idx);
      sif.s_last = 1'b0;
      idx++;
      tick();
    end
    reset = 1'b1;
    sif.s_valid = 1'b0;
    @(negedge clk);
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_b("mid_rst_s_ready", sif.s_ready, 1'b0);
    chk_b("mid_rst_m_valid", sif.m_valid, 1'b0);
    chk_w("mid_rst_m_data", sif.m_data, '0);
    chk_b("mid_rst_enc_start", enc_start, 1'b0);
    chk_i("mid_rst_blk_count", int'(blk_count), 0);
    tick();
    tick();
    reset = 1'b0;
    mv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sif.m_valid) mv_seen++;
      tick();
    end
    chk_i("late_ks_dropped", mv_seen, 0);

    out_q.delete();
    do_start(iv4);
    send_blk(bpd(300), 1'b1);
    wait_out(1);
    chk_i("rekey_after_rst", kx_pulses, kxp + 1);
    chk_w("post_rst_ct", out_q[0].data, bpd(300) ^ ks(iv4));
    chk_b("post_rst_last", out_q[0].last, 1'b1);
    wait_idle();
    chk_i("post_rst_blk_count", int'(blk_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/adam_aes_ctr_stream.md
Name: adam_aes_ctr_stream

Overview:
- Parametrised AES-CTR streaming engine; successor to the single-block AES core controller.
- Accepts plaintext blocks on a valid/ready stream and issues one counter block per cycle to an external fully pipelined encipher and key expansion.
- XORs the returned keystream with buffered data and emits ciphertext on a valid/ready stream.
- Encrypt-only cipher path; CTR decrypt is the same operation.

Parameters:
- PIPE_LAT, 11, fixed encipher latency in cycles from enc_start to enc_valid; used only for assertions.
- DEPTH, 16, maximum blocks in flight plus buffered (power of 2, ≥ PIPE_LAT+2).
- CTR_W, 32, width of the incrementing low counter field (8..128).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse: load iv, check key, begin message
- iv  in  128  initial counter block
- key  in  256  cipher key
- keylen  in  1  0=128-bit, 1=256-bit
- s_valid  in  1  input block valid
- s_ready  out  1  input block accepted when high with s_valid
- s_data  in  128  plaintext block
- s_last  in  1  final block of message
- m_valid  out  1  output block valid
- m_ready  in  1  downstream ready
- m_data  out  128  ciphertext block
- m_last  out  1  final block marker
- kx_init  out  1  key-expansion start pulse
- kx_ready  in  1  round keys valid
- enc_start  out  1  issue counter block to pipeline
- enc_block  out  128  counter block
- enc_valid  in  1  keystream valid
- enc_result  in  128  keystream block
- busy  out  1  state != IDLE
- ctr_wrap  out  1  sticky: low counter field wrapped this message
- blk_count  out  32  blocks emitted since last start (wraps mod 2^32)

Behaviour:
- Reset values:
  - s_ready=0, m_valid=0, m_last=0, m_data=0.
  - kx_init=0, enc_start=0, busy=0, ctr_wrap=0, blk_count=0.
  - Key-valid flag cleared; FIFOs empty; state IDLE.
- States and transitions:
  - IDLE: start with key/keylen differing from the stored copy, or no valid key → latch key/keylen/iv, go to KEY_INIT. Otherwise latch iv and go to RUN. start outside IDLE is ignored.
  - KEY_INIT: assert kx_init for one cycle, then go to KEY_WAIT.
  - KEY_WAIT: on kx_ready set the key-valid flag and go to RUN.
  - RUN: s_ready = credit < DEPTH. Each accepted beat (see Issue below). Accepting a beat with s_last=1 → DRAIN.
  - DRAIN: s_ready=0. When credit==0 → IDLE.
- Issue (per accepted beat in RUN):
  - Same cycle: enc_start=1, enc_block=counter.
  - {s_data, s_last} pushed to data FIFO; counter low CTR_W bits +1 mod 2^CTR_W; upper 128-CTR_W bits unchanged.
  - Throughput: 1 block/cycle.
- Credit:
  - credit = issued − emitted; +1 on accept, −1 on m_valid&&m_ready; simultaneous events net 0.
  - The output FIFO can never overflow, so enc_valid is never back-pressured.
- Keystream:
  - On enc_valid, pop data FIFO head and push {head.data ^ enc_result, head.last} into output FIFO.
  - enc_valid with an empty data FIFO is an assertion failure.
- Output:
  - m_valid = output FIFO not empty; data/last held stable while m_valid && !m_ready.
  - Minimum latency s accept → m_valid = PIPE_LAT+1 cycles.
- Counters:
  - ctr_wrap set when low field goes all-ones→0; cleared on accepted start.
  - blk_count cleared on accepted start; +1 per output handshake.
- Reset mid-operation: all state, FIFOs, credit and key-valid flag cleared immediately; in-flight keystream arriving after reset is dropped.
- A key change always requires a new start; key/keylen/iv are sampled only at start.

Optional Feature:
- Macro: ADAM_AES_CTR_WRAP_STOP_EN.
- Defined: once the counter wraps, s_ready=0 for the rest of the message. State goes to DRAIN without s_last; the last emitted block carries m_last=1 (forced on the final queued entry).
- Undefined: counter wraps silently; only ctr_wrap flags it.

Decomposition:
- Package adam_aes_ctr_pkg:
  - state_t enum (IDLE, KEY_INIT, KEY_WAIT, RUN, DRAIN).
  - blk_t = logic[127:0].
  - entry_t struct {blk_t data; logic last}.
  - ctr_inc function (CTR_W-masked increment).
- Sub-module adam_aes_ctr_fifo: parametrised synchronous FIFO (entry_t, DEPTH) with full/empty/count. Instantiated twice: data FIFO and output FIFO.

Test Plan:
- NIST SP800-38A F.5.1:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, keylen=0, iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; 4 blocks starting 6bc1bee22e409f96e93d7e117393172a, s_last on block 4.
  - Expected: m_data[0]=874d6191b620e3261bef6864990db6ce; all 4 ciphertexts match; m_last on block 4 only; blk_count=4.
- Back-to-back same key: second start with identical key → no kx_init pulse; enc_start in the cycle after start; second-message ciphertexts correct.
- Back-pressure:
  - Stimulus: m_ready=0 for 40 cycles with continuous s_valid.
  - Expected: exactly DEPTH=16 beats accepted, then s_ready=0; m_data stable; after release, all 16 blocks emitted in order with none lost.
- Wrap:
  - Stimulus: CTR_W=32, iv low word ffffffff, 2 blocks.
  - Expected: enc_block[1] low word 00000000, upper 96 bits unchanged; ctr_wrap=1.
  - With ADAM_AES_CTR_WRAP_STOP_EN: s_ready drops after block 1 and m_last is set on it.
- Reset mid-RUN: assert reset with 5 blocks in flight → all outputs return to reset values next edge; no m_valid from late enc_valid; next start re-expands the key.
- Simultaneous accept and emit at credit=DEPTH−1: credit unchanged; s_ready stays high.
